// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Loads and illegal accesses are answered one cycle after the grant.
module mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [31:0]       A_WDATA,
    input  logic [1:0]        A_SIZE,
    input  logic              A_SIGNED,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [31:0]       B_WDATA,
    input  logic [1:0]        B_SIZE,
    input  logic              B_SIGNED,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [31:0]       A_RDATA,
    output logic              A_ERR,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [31:0]       B_RDATA,
    output logic              B_ERR,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [31:0]       M_DATA_IN,
    output logic [1:0]        M_DATA_SIZE,
    output logic              M_SIGNED,
    input  logic [31:0]       M_DATA_OUT
);

    typedef enum logic [1:0] {RESP_IDLE, RESP_RD, RESP_ERR} resp_t;

    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            2'b10:   return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    logic  r_last;        // 0 = A granted last, 1 = B granted last
    resp_t r_resp_p1;
    logic  r_owner_p1;
    resp_t w_resp_nxt;
    logic  w_owner_nxt;
    logic  w_gnt_a;
    logic  w_gnt_b;
    logic  w_gnt_any;
    logic  w_we;
    logic  w_legal;
    logic  w_resp_vld;
    logic [31:0] w_rdata;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!RST) begin
            if (A_REQ && B_REQ) begin
                w_gnt_a = r_last;
                w_gnt_b = ~r_last;
            end else begin
                w_gnt_a = A_REQ;
                w_gnt_b = B_REQ;
            end
        end
    end

    assign w_gnt_any = w_gnt_a | w_gnt_b;
    assign A_GNT     = w_gnt_a;
    assign B_GNT     = w_gnt_b;

    // Memory port follows the grantee, defaulting to A when idle
    assign M_ADDR      = w_gnt_b ? B_ADDR   : A_ADDR;
    assign M_DATA_IN   = w_gnt_b ? B_WDATA  : A_WDATA;
    assign M_DATA_SIZE = w_gnt_b ? B_SIZE   : A_SIZE;
    assign M_SIGNED    = w_gnt_b ? B_SIGNED : A_SIGNED;
    assign w_we        = w_gnt_b ? B_WE     : A_WE;
    assign w_legal     = access_legal(M_DATA_SIZE, M_ADDR[1:0]);
    assign M_WE        = w_gnt_any & w_we & w_legal;

    always_comb begin
        w_resp_nxt  = RESP_IDLE;
        w_owner_nxt = r_owner_p1;
        if (w_gnt_any) begin
            w_owner_nxt = w_gnt_b;
            if (!w_legal)
                w_resp_nxt = RESP_ERR;
            else if (!w_we)
                w_resp_nxt = RESP_RD;
        end
    end

    // Stage p0 -> p1: response owed for the access granted this cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_resp_p1  <= RESP_IDLE;
            r_owner_p1 <= 1'b0;
            r_last     <= 1'b1;
        end else begin
            r_resp_p1  <= w_resp_nxt;
            r_owner_p1 <= w_owner_nxt;
            if (w_gnt_any)
                r_last <= w_gnt_b;
        end
    end

    assign w_resp_vld = !RST && (r_resp_p1 != RESP_IDLE);
    assign w_rdata    = (r_resp_p1 == RESP_RD) ? M_DATA_OUT : 32'h0;

    assign A_RVALID = w_resp_vld & ~r_owner_p1;
    assign B_RVALID = w_resp_vld &  r_owner_p1;
    assign A_ERR    = A_RVALID & (r_resp_p1 == RESP_ERR);
    assign B_ERR    = B_RVALID & (r_resp_p1 == RESP_ERR);
    assign A_RDATA  = A_RVALID ? w_rdata : 32'h0;
    assign B_RDATA  = B_RVALID ? w_rdata : 32'h0;

endmodule
